control_unit: RTL and testbench

//  Main decoder for the 32-bit MIPS-subset single-cycle datapath. Decodes Op/Fun into datapath control

---
 rtl/control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_control_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Main decoder for the MIPS-subset single-cycle datapath: turns Op/Fun plus the
// ALU equal/sign flags into registered datapath strobes (one cycle of latency).
module control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Fun,
   input  logic       equal,
   input  logic       sign,
   output logic       nPC_sel,
   output logic       RegWr,
   output logic       RegDst,
   output logic       ExtOp,
   output logic       ALUSrc,
   output logic [2:0] ALUctr,
   output logic       MemWr,
   output logic       MemtoReg
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_SLT  = 3'b100,
      ALU_SLTU = 3'b101,
      ALU_XOR  = 3'b110,
      ALU_NOR  = 3'b111
   } alu_op_t;

   logic       w_nPC_sel;
   logic       w_RegWr;
   logic       w_RegDst;
   logic       w_ExtOp;
   logic       w_ALUSrc;
   alu_op_t    w_ALUctr;
   logic       w_MemWr;
   logic       w_MemtoReg;

   logic       r_nPC_sel;
   logic       r_RegWr;
   logic       r_RegDst;
   logic       r_ExtOp;
   logic       r_ALUSrc;
   logic [2:0] r_ALUctr;
   logic       r_MemWr;
   logic       r_MemtoReg;

   // Anything not matched (including X/Z on Op or Fun) falls through to an all-zero NOP.
   always_comb begin
      w_nPC_sel  = 1'b0;
      w_RegWr    = 1'b0;
      w_RegDst   = 1'b0;
      w_ExtOp    = 1'b0;
      w_ALUSrc   = 1'b0;
      w_ALUctr   = ALU_ADD;
      w_MemWr    = 1'b0;
      w_MemtoReg = 1'b0;
      case (Op)
         OP_RTYPE: begin
            w_RegWr  = 1'b1;
            w_RegDst = 1'b1;
            case (Fun)
               FN_ADD, FN_ADDU: w_ALUctr = ALU_ADD;
               FN_SUB, FN_SUBU: w_ALUctr = ALU_SUB;
               FN_AND:          w_ALUctr = ALU_AND;
               FN_OR:           w_ALUctr = ALU_OR;
               FN_XOR:          w_ALUctr = ALU_XOR;
               FN_NOR:          w_ALUctr = ALU_NOR;
               FN_SLT:          w_ALUctr = ALU_SLT;
               FN_SLTU:         w_ALUctr = ALU_SLTU;
               default: begin
                  w_RegWr  = 1'b0;
                  w_RegDst = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            w_RegWr  = 1'b1;
            w_ALUSrc = 1'b1;
            w_ExtOp  = 1'b1;
            w_ALUctr = ALU_ADD;
         end
         OP_SLTI: begin
            w_RegWr  = 1'b1;
            w_ALUSrc = 1'b1;
            w_ExtOp  = 1'b1;
            w_ALUctr = ALU_SLT;
         end
         OP_SLTIU: begin
            w_RegWr  = 1'b1;
            w_ALUSrc = 1'b1;
            w_ExtOp  = 1'b1;
            w_ALUctr = ALU_SLTU;
         end
         OP_ANDI: begin
            w_RegWr  = 1'b1;
            w_ALUSrc = 1'b1;
            w_ALUctr = ALU_AND;
         end
         OP_ORI: begin
            w_RegWr  = 1'b1;
            w_ALUSrc = 1'b1;
            w_ALUctr = ALU_OR;
         end
         OP_XORI: begin
            w_RegWr  = 1'b1;
            w_ALUSrc = 1'b1;
            w_ALUctr = ALU_XOR;
         end
         OP_LW: begin
            w_RegWr    = 1'b1;
            w_ALUSrc   = 1'b1;
            w_ExtOp    = 1'b1;
            w_MemtoReg = 1'b1;
         end
         OP_SW: begin
            w_MemWr  = 1'b1;
            w_ALUSrc = 1'b1;
            w_ExtOp  = 1'b1;
         end
         // Branches compare via subtraction; the flags only matter here.
         OP_BEQ: begin
            w_ExtOp   = 1'b1;
            w_ALUctr  = ALU_SUB;
            w_nPC_sel = equal;
         end
         OP_BNE: begin
            w_ExtOp   = 1'b1;
            w_ALUctr  = ALU_SUB;
            w_nPC_sel = ~equal;
         end
         OP_BLEZ: begin
            w_ExtOp   = 1'b1;
            w_ALUctr  = ALU_SUB;
            w_nPC_sel = equal | sign;
         end
         OP_BGTZ: begin
            w_ExtOp   = 1'b1;
            w_ALUctr  = ALU_SUB;
            w_nPC_sel = ~equal & ~sign;
         end
         default: ;
      endcase
   end

   // Output register: cleared asynchronously, otherwise loads the decode each edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_nPC_sel  <= 1'b0;
         r_RegWr    <= 1'b0;
         r_RegDst   <= 1'b0;
         r_ExtOp    <= 1'b0;
         r_ALUSrc   <= 1'b0;
         r_ALUctr   <= 3'b000;
         r_MemWr    <= 1'b0;
         r_MemtoReg <= 1'b0;
      end else begin
         r_nPC_sel  <= w_nPC_sel;
         r_RegWr    <= w_RegWr;
         r_RegDst   <= w_RegDst;
         r_ExtOp    <= w_ExtOp;
         r_ALUSrc   <= w_ALUSrc;
         r_ALUctr   <= w_ALUctr;
         r_MemWr    <= w_MemWr;
         r_MemtoReg <= w_MemtoReg;
      end
   end

   assign nPC_sel  = r_nPC_sel;
   assign RegWr    = r_RegWr;
   assign RegDst   = r_RegDst;
   assign ExtOp    = r_ExtOp;
   assign ALUSrc   = r_ALUSrc;
   assign ALUctr   = r_ALUctr;
   assign MemWr    = r_MemWr;
   assign MemtoReg = r_MemtoReg;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed reset/hold cases plus random instructions,
// checked through a scoreboard queue against a mnemonic-level reference model.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op;
   logic [5:0] Fun;
   logic       equal;
   logic       sign;
   logic       nPC_sel, RegWr, RegDst, ExtOp, ALUSrc, MemWr, MemtoReg;
   logic [2:0] ALUctr;

   typedef logic [9:0] ctrl_t;

   ctrl_t      expQ[$];
   ctrl_t      actual;
   int         errors = 0;
   int         checks = 0;

   control_unit dut (
      .clk      (clk),
      .reset    (reset),
      .Op       (Op),
      .Fun      (Fun),
      .equal    (equal),
      .sign     (sign),
      .nPC_sel  (nPC_sel),
      .RegWr    (RegWr),
      .RegDst   (RegDst),
      .ExtOp    (ExtOp),
      .ALUSrc   (ALUSrc),
      .ALUctr   (ALUctr),
      .MemWr    (MemWr),
      .MemtoReg (MemtoReg)
   );

   always #5 clk = ~clk;

   assign actual = {nPC_sel, RegWr, RegDst, ExtOp, ALUSrc, ALUctr, MemWr, MemtoReg};

   // Instruction name from its encoding; unlisted encodings are "nop".
   function automatic string mnemonic(input logic [5:0] op, input logic [5:0] fun);
      string m;
      m = "nop";
      case (op)
         6'd0: case (fun)
            6'b100000: m = "add";
            6'b100001: m = "addu";
            6'b100010: m = "sub";
            6'b100011: m = "subu";
            6'b100100: m = "and";
            6'b100101: m = "or";
            6'b100110: m = "xor";
            6'b100111: m = "nor";
            6'b101010: m = "slt";
            6'b101011: m = "sltu";
            default:   m = "nop";
         endcase
         6'b001000: m = "addi";
         6'b001001: m = "addiu";
         6'b001100: m = "andi";
         6'b001101: m = "ori";
         6'b001110: m = "xori";
         6'b001010: m = "slti";
         6'b001011: m = "sltiu";
         6'b100011: m = "lw";
         6'b101011: m = "sw";
         6'b000100: m = "beq";
         6'b000101: m = "bne";
         6'b000110: m = "blez";
         6'b000111: m = "bgtz";
         default:   m = "nop";
      endcase
      return m;
   endfunction

   // Control word derived from instruction class and operation rather than opcode bits.
   function automatic ctrl_t refModel(input logic [5:0] op, input logic [5:0] fun,
                                      input logic eq, input logic sg);
      string m;
      logic [2:0] alu;
      bit isR, isImm, isBr, signedImm, take;
      m = mnemonic(op, fun);
      if (m == "nop") return '0;
      isR = 0; isImm = 0; isBr = 0; signedImm = 0; take = 0; alu = 3'd0;
      case (m)
         "add", "addu", "sub", "subu", "and", "or", "xor", "nor", "slt", "sltu": isR = 1;
         "addi", "addiu", "andi", "ori", "xori", "slti", "sltiu": isImm = 1;
         "beq", "bne", "blez", "bgtz": isBr = 1;
         default: ;
      endcase
      case (m)
         "sub", "subu", "beq", "bne", "blez", "bgtz": alu = 3'd1;
         "and", "andi":   alu = 3'd2;
         "or", "ori":     alu = 3'd3;
         "slt", "slti":   alu = 3'd4;
         "sltu", "sltiu": alu = 3'd5;
         "xor", "xori":   alu = 3'd6;
         "nor":           alu = 3'd7;
         default:         alu = 3'd0;
      endcase
      case (m)
         "addi", "addiu", "slti", "sltiu", "lw", "sw": signedImm = 1;
         default: signedImm = isBr;
      endcase
      case (m)
         "beq":  take = eq;
         "bne":  take = !eq;
         "blez": take = eq || sg;
         "bgtz": take = !eq && !sg;
         default: take = 0;
      endcase
      return {take, isR || isImm || (m == "lw"), isR, signedImm,
              isImm || (m == "lw") || (m == "sw"), alu, (m == "sw"), (m == "lw")};
   endfunction

   task automatic checkOutput(input string name, input ctrl_t exp);
      checks++;
      if (actual !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%b expected=%b (nPC RegWr RegDst ExtOp ALUSrc ALUctr MemWr MemtoReg) Op=%b Fun=%b",
                  name, actual, exp, Op, Fun);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fun,
                                input logic eq, input logic sg);
      @(negedge clk);
      #1;
      Op = op; Fun = fun; equal = eq; sign = sg;
      @(posedge clk);
      expQ.push_back(refModel(op, fun, eq, sg));
   endtask

   // Monitor: outputs registered at a rising edge are compared at the following falling edge.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         ctrl_t e;
         e = expQ.pop_front();
         checkOutput("scoreboard", e);
      end
   end

   logic [5:0] validOps [14] = '{6'b000000, 6'b001000, 6'b001001, 6'b001100, 6'b001101,
                                 6'b001110, 6'b001010, 6'b001011, 6'b100011, 6'b101011,
                                 6'b000100, 6'b000101, 6'b000110, 6'b000111};
   logic [5:0] validFuns [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                  6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};

   initial begin
      logic [5:0] rop, rfun;
      reset = 1'b1; Op = 6'b000000; Fun = 6'b100000; equal = 1'b0; sign = 1'b0;
      #1;
      checkOutput("reset_no_edge", '0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("reset_held", '0);
      end
      #2 reset = 1'b0;

      applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b0);
      applyStimulus(6'b000100, 6'b000000, 1'b1, 1'b0);
      applyStimulus(6'b000100, 6'b000000, 1'b0, 1'b0);
      applyStimulus(6'b100011, 6'b000000, 1'b1, 1'b1);
      applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0);
      applyStimulus(6'b001101, 6'b000000, 1'b0, 1'b0);
      applyStimulus(6'b000111, 6'b000000, 1'b0, 1'b0);
      applyStimulus(6'b000111, 6'b000000, 1'b0, 1'b1);
      applyStimulus(6'b000110, 6'b000000, 1'b0, 1'b1);
      applyStimulus(6'b000101, 6'b000000, 1'b0, 1'b0);
      applyStimulus(6'b111111, 6'b100000, 1'b1, 1'b0);
      applyStimulus(6'b000000, 6'b000001, 1'b0, 1'b0);
      applyStimulus(6'b001000, 6'b100000, 1'b1, 1'b1);

      // Asynchronous reset arriving between edges must clear outputs at once.
      applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 checkOutput("async_reset", '0);
      @(negedge clk);
      checkOutput("reset_through_edge", '0);
      #2 reset = 1'b0;

      // Input changes without an edge must leave outputs alone.
      applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b0);
      @(negedge clk);
      #2 Op = 6'b111111;
      #1 checkOutput("hold_lw", refModel(6'b100011, 6'b000000, 1'b0, 1'b0));
      applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b0);
      @(negedge clk);
      #2 Op = 6'b100011;
      #1 checkOutput("hold_nop", '0);

      for (int i = 0; i < 300; i++) begin
         rop  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : validOps[$urandom_range(0, 13)];
         rfun = ($urandom_range(0, 5) == 0) ? 6'($urandom) : validFuns[$urandom_range(0, 9)];
         applyStimulus(rop, rfun, 1'($urandom), 1'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
